// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU controller: ADD/SUB single pass, MUL as an 8-step shift-add loop,
// all sharing one 8-bit add/sub datapath, with valid/ready request and result handshakes.
module add_sub_8_bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       m,
  output logic [7:0] sum,
  output logic       c_out
);
  logic [8:0] total;

  // m=1 turns the adder into x - y via two's complement; c_out=1 then means no borrow
  assign total = 9'(x) + 9'(y ^ {8{m}}) + 9'(m);
  assign sum   = total[7:0];
  assign c_out = total[8];
endmodule

module alu_seq_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           err,
  output logic           busy
);
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [1:0]       op_r;
  logic [W-1:0]     acc;
  logic [W-1:0]     q;
  logic [CNT_W-1:0] cnt;

  logic [W-1:0]     add_x;
  logic [W-1:0]     add_y;
  logic             add_m;
  logic [W-1:0]     add_sum;
  logic             add_c;

  // Operand mux: EXEC uses captured operands, MUL adds the multiplicand to acc when q[0] is set
  always_comb begin
    add_x = a_r;
    add_y = b_r;
    if (state == S_MUL) begin
      add_x = acc;
      add_y = q[0] ? a_r : '0;
    end
  end

  assign add_m = (op_r == OP_SUB);

  add_sub_8_bit u_add (
    .x     (add_x),
    .y     (add_y),
    .m     (add_m),
    .sum   (add_sum),
    .c_out (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      acc         <= '0;
      q           <= '0;
      cnt         <= '0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid && start_ready) begin
            a_r         <= a;
            b_r         <= b;
            op_r        <= op;
            acc         <= '0;
            q           <= b;
            cnt         <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= (op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_r == OP_RSV) begin
            result <= '0;
            carry  <= 1'b0;
            err    <= 1'b1;
          end else begin
            result <= {W'(0), add_sum};
            carry  <= add_c;
            err    <= 1'b0;
          end
          state <= S_DONE;
        end
        S_MUL: begin
          {acc, q} <= {add_c, add_sum, q[W-1:1]};
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            result <= {add_c, add_sum, q[W-1:1]};
            carry  <= 1'b0;
            err    <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Result lands one cycle before res_valid rises, then is held until taken
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table for single ops plus backpressure
// and mid-multiply reset sequences.
module tb_alu_seq_ctrl;
  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        carry;
  logic        err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry       (carry),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, then wait (bounded) for res_valid; latency counts edges after accept
  task automatic do_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] r, output logic c, output logic e, output int lat);
    int guard;
    guard = 0;
    while (!start_ready && guard < 50) begin
      tick();
      guard++;
    end
    op = o;
    a = x;
    b = y;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    op = 2'b00;
    a = 8'h5A;
    b = 8'hA5;
    lat = 0;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
    r = result;
    c = carry;
    e = err;
  endtask

  initial begin
    logic [15:0] r;
    logic        c;
    logic        e;
    int          lat;

    vecs[0] = '{2'b00, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, 2};
    vecs[1] = '{2'b01, 8'h05, 8'h07, 16'h00FE, 1'b0, 1'b0, 2};
    vecs[2] = '{2'b01, 8'h07, 8'h05, 16'h0002, 1'b1, 1'b0, 2};
    vecs[3] = '{2'b10, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9};
    vecs[4] = '{2'b10, 8'h00, 8'hC3, 16'h0000, 1'b0, 1'b0, 9};
    vecs[5] = '{2'b10, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 9};
    vecs[6] = '{2'b11, 8'hAA, 8'h55, 16'h0000, 1'b0, 1'b1, 2};
    vecs[7] = '{2'b00, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 2};
    vecs[8] = '{2'b00, 8'h80, 8'h80, 16'h0000, 1'b1, 1'b0, 2};
    vecs[9] = '{2'b10, 8'h03, 8'h81, 16'h0183, 1'b0, 1'b0, 9};

    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op = 2'b00;
    a = 8'h00;
    b = 8'h00;
    #3;
    check("reset start_ready", 32'(start_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset carry/err", 32'({carry, err}), 32'd0);
    #9;
    rst = 1'b0;
    tick();

    // Table of single operations, consumer always ready
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, e, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d carry", i), 32'(c), 32'(vecs[i].c));
      check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].e));
      tick();
      check($sformatf("vec%0d ready after take", i), 32'({start_ready, busy, res_valid}), 32'b100);
    end

    // Backpressure: result held, new request ignored while busy
    res_ready = 1'b0;
    do_op(2'b00, 8'h12, 8'h34, r, c, e, lat);
    check("bp latency", 32'(lat), 32'd2);
    op = 2'b10;
    a = 8'hFF;
    b = 8'hFF;
    start_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp hold%0d", k), 32'({res_valid, start_ready, busy, carry, err, result}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0046}));
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    check("bp release", 32'({start_ready, busy, res_valid, result}), 32'({3'b100, 16'h0046}));
    tick();
    check("bp not queued", 32'({busy, res_valid}), 32'd0);

    // Asynchronous reset in the middle of a multiply
    op = 2'b10;
    a = 8'h0F;
    b = 8'h0F;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("mid-mul busy", 32'({busy, start_ready}), 32'b10);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ready/busy", 32'({start_ready, busy, res_valid}), 32'b100);
    check("async rst result", 32'({result, carry, err}), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    check("post-rst idle", 32'({start_ready, busy}), 32'b10);
    do_op(2'b10, 8'h10, 8'h10, r, c, e, lat);
    check("post-rst mul latency", 32'(lat), 32'd9);
    check("post-rst mul result", 32'(r), 32'h0100);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
